// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared definitions for the sequential carry-lookahead adder controller.
// Slice width, FSM state encodings and a slice-count helper.
package cla_seq_adder_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Start/done handshake and operand/result bus between the ALU control FSM
// and the sequential adder controller.
interface cla_seq_adder_ctrl_if #(
    parameter int WIDTH = 32
);

    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_ci;

    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_s;
    logic             o_co;
    logic             o_ov;

    modport master (
        output i_start,
        output i_sub,
        output i_a,
        output i_b,
        output i_ci,
        input  o_busy,
        input  o_done,
        input  o_s,
        input  o_co,
        input  o_ov
    );

    modport slave (
        input  i_start,
        input  i_sub,
        input  i_a,
        input  i_b,
        input  i_ci,
        output o_busy,
        output o_done,
        output o_s,
        output o_co,
        output o_ov
    );

endinterface

// File: rtl/cla_seq_adder_ctrl_slice.sv
// 4-bit carry-lookahead slice from gate primitives.
// Exposes the carry into bit 3 so the caller can form signed overflow.
module cla4_slice
    import cla_seq_adder_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               c3,
    output logic               co
);

    wire [3:0] p;
    wire [3:0] g;
    wire [3:0] c;
    wire       t10;
    wire       t20, t21;
    wire       t30, t31, t32;
    wire       t40, t41, t42, t43;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_pg
            xor u_p (p[i], a[i], b[i]);
            and u_g (g[i], a[i], b[i]);
            xor u_s (s[i], p[i], c[i]);
        end
    endgenerate

    assign c[0] = ci;

    and u_t10 (t10, p[0], ci);
    or  u_c1  (c[1], g[0], t10);

    and u_t20 (t20, p[1], g[0]);
    and u_t21 (t21, p[1], p[0], ci);
    or  u_c2  (c[2], g[1], t20, t21);

    and u_t30 (t30, p[2], g[1]);
    and u_t31 (t31, p[2], p[1], g[0]);
    and u_t32 (t32, p[2], p[1], p[0], ci);
    or  u_c3  (c[3], g[2], t30, t31, t32);

    // Block carry-out is flattened, not rippled through c[3]
    and u_t40 (t40, p[3], g[2]);
    and u_t41 (t41, p[3], p[2], g[1]);
    and u_t42 (t42, p[3], p[2], p[1], g[0]);
    and u_t43 (t43, p[3], p[2], p[1], p[0], ci);
    or  u_co  (co, g[3], t40, t41, t42, t43);

    assign c3 = c[3];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle adder/subtractor: one 4-bit CLA slice reused over WIDTH/4
// cycles, LSB slice first, with a registered inter-slice carry.
module cla_seq_adder_ctrl
    import cla_seq_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset_n,
    cla_seq_adder_ctrl_if.slave bus
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int CW     = cnt_bits(NSLICE);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;

    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ov_q;
    logic             done_q;

    logic             exec;
    logic             accept;
    logic             last;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_c3;
    logic               sl_co;

    assign exec   = (state == ST_EXEC);
    assign accept = bus.i_start && !exec;
    assign last   = exec && (cnt == CW'(NSLICE - 1));

    assign sl_a = opa[int'(cnt)*SLICE_W +: SLICE_W];
    assign sl_b = opb[int'(cnt)*SLICE_W +: SLICE_W];

    cla4_slice u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry),
        .s  (sl_s),
        .c3 (sl_c3),
        .co (sl_co)
    );

    always_comb begin
        work_nxt = work;
        work_nxt[int'(cnt)*SLICE_W +: SLICE_W] = sl_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.i_start) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = bus.i_start ? ST_EXEC : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            work   <= '0;
            s_q    <= '0;
            co_q   <= 1'b0;
            ov_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                opa   <= bus.i_a;
                opb   <= bus.i_b ^ {WIDTH{bus.i_sub}};
                carry <= bus.i_sub ? 1'b1 : bus.i_ci;
                cnt   <= '0;
            end else if (exec) begin
                work  <= work_nxt;
                carry <= sl_co;
                if (last) begin
                    // Counter parks on the last slice; it is reloaded on accept
                    s_q    <= work_nxt;
                    co_q   <= sl_co;
                    ov_q   <= sl_c3 ^ sl_co;
                    done_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.o_busy = exec;
    assign bus.o_done = done_q;
    assign bus.o_s    = s_q;
    assign bus.o_co   = co_q;
    assign bus.o_ov   = ov_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Scoreboard bench for the sequential CLA adder controller (WIDTH = 32).
// Directed arithmetic, handshake, back-to-back, mid-op reset, random ops.
module tb_cla_seq_adder_ctrl;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t q[$];

    always #5 clk = ~clk;

    cla_seq_adder_ctrl_if #(.WIDTH(W)) bus ();

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic res_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic sub,
                                   input logic ci);
        logic [W-1:0] bb;
        logic [W:0]   sum;
        res_t         r;
        bb    = sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : ci)};
        r.s   = sum[W-1:0];
        r.co  = sum[W];
        r.ov  = (a[W-1] == bb[W-1]) && (r.s[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.s  = bus.o_s;
        r.co = bus.o_co;
        r.ov = bus.o_ov;
        return r;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic ci);
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_sub   = sub;
        bus.i_ci    = ci;
        bus.i_start = 1'b1;
        q.push_back(model(a, b, sub, ci));
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic ci);
        drive(a, b, sub, ci);
        @(posedge clk);
        #1 bus.i_start = 1'b0;
    endtask

    // lat: negedges after the accept-edge sample until o_done
    task automatic wait_done(input bit scramble, output int lat,
                             output int busy_n, output bit to,
                             output bit moved);
        logic [W-1:0] s0;
        s0 = bus.o_s;
        lat = 0;
        busy_n = 0;
        to = 1'b1;
        moved = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_done) begin
                lat = i;
                to = 1'b0;
                break;
            end
            if (bus.o_busy) busy_n++;
            if (bus.o_s !== s0) moved = 1'b1;
            if (scramble) begin
                bus.i_a   = $urandom;
                bus.i_b   = $urandom;
                bus.i_sub = 1'($urandom);
                bus.i_ci  = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_sub   = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_ci    = 1'b0;
        reset_n     = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_busy, bus.o_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00", {bus.o_busy, bus.o_done});
        end
        checks++;
        if (observed() !== '0) begin
            errors++;
            $display("FAIL reset_res got %h want 0", observed());
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        vec_t v[8];
        res_t e, o;
        int   lat, bn;
        bit   to, mv;
        v[0] = {32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        v[1] = {32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        v[2] = {32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        v[3] = {32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        v[4] = {32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        v[5] = {32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        v[6] = {32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
        v[7] = {32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            issue(v[k].a, v[k].b, v[k].sub, v[k].ci);
            wait_done(1'b0, lat, bn, to, mv);
            checks++;
            if (to || lat != 8 || bn != 8) begin
                errors++;
                $display("FAIL add_lat[%0d] got lat=%0d busy=%0d to=%0b want 8/8/0",
                         k, lat, bn, to);
            end
            checks++;
            if (mv) begin
                errors++;
                $display("FAIL add_stable[%0d] got o_s moved want held", k);
            end
            o = observed();
            checks++;
            if (o !== {v[k].s, v[k].co, v[k].ov}) begin
                errors++;
                $display("FAIL add_vec[%0d] got %h want %h",
                         k, o, {v[k].s, v[k].co, v[k].ov});
            end
            e = (q.size() > 0) ? q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL add_sb[%0d] got %h want %h", k, o, e);
            end
            @(negedge clk);
            checks++;
            if ({bus.o_done, bus.o_busy} !== 2'b00 || observed() !== o) begin
                errors++;
                $display("FAIL add_pulse[%0d] got done=%0b busy=%0b s=%h want 0/0/%h",
                         k, bus.o_done, bus.o_busy, observed(), o);
            end
        end
    endtask

    task automatic test_handshake();
        res_t e, o;
        int   lat, bn, extra;
        bit   to, mv;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.i_a     = 32'hDEAD_BEEF;
        bus.i_b     = 32'h0BAD_F00D;
        bus.i_sub   = 1'b1;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        wait_done(1'b0, lat, bn, to, mv);
        o = observed();
        e = (q.size() > 0) ? q.pop_front() : 'x;
        checks++;
        if (to || o !== e) begin
            errors++;
            $display("FAIL hs_ignore got %h to=%0b want %h", o, to, e);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL hs_noqueue got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        int   lat, bn;
        bit   to, mv;
        drive(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        wait_done(1'b0, lat, bn, to, mv);
        o = observed();
        e = (q.size() > 0) ? q.pop_front() : 'x;
        checks++;
        if (to || o !== e || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got %h busy=%0b to=%0b want %h busy=0",
                     o, bus.o_busy, to, e);
        end
        drive(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        wait_done(1'b0, lat, bn, to, mv);
        checks++;
        if (to || lat != 8 || bn != 8) begin
            errors++;
            $display("FAIL b2b_lat got lat=%0d busy=%0d to=%0b want 8/8/0",
                     lat, bn, to);
        end
        o = observed();
        e = (q.size() > 0) ? q.pop_front() : 'x;
        checks++;
        if (o !== e || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got %h busy=%0b want %h busy=0",
                     o, bus.o_busy, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        res_t e, o;
        int   lat, bn, dn;
        bit   to, mv;
        issue(32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (observed() !== '0 || {bus.o_busy, bus.o_done} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid got res=%h busy=%0b done=%0b want 0/0/0",
                     observed(), bus.o_busy, bus.o_done);
        end
        dn = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.o_done) dn++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL rst_nodone got %0d active cycles want 0", dn);
        end
        q.delete();
        issue(32'd3, 32'd4, 1'b0, 1'b0);
        wait_done(1'b0, lat, bn, to, mv);
        o = observed();
        e = (q.size() > 0) ? q.pop_front() : 'x;
        checks++;
        if (to || o.s !== 32'd7 || o !== e) begin
            errors++;
            $display("FAIL rst_fresh got %h to=%0b want s=7 %h", o, to, e);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        res_t         e, o;
        int           lat, bn, bad;
        bit           to, mv;
        logic [W-1:0] a, b;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = $urandom;
            if (n % 8 == 1) a = 32'hFFFF_FFFF;
            if (n % 8 == 3) b = 32'h8000_0000;
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
            issue(a, b, 1'($urandom), 1'($urandom));
            wait_done(1'b1, lat, bn, to, mv);
            o = observed();
            e = (q.size() > 0) ? q.pop_front() : 'x;
            checks++;
            if (to || lat != 8 || mv || o !== e) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand[%0d] got %h lat=%0d to=%0b mv=%0b want %h",
                             n, o, lat, to, mv, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
